sim_run_ctrl: RTL
=================

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, memory word width.
- ADDR_W, 10, memory word-address width.
- IMEM_WORDS, 256, instruction words loaded.
- DMEM_WORDS, 256, data words cleared and then loaded.
- RST_CYCLES, 2, CPU reset pulse length.
- MAX_CYCLES, 2500, run budget.
- CNT_W, 16, cycle counter width.
- TRAP_WORD, 32'h44000300, halt instruction.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin a run sequence.
- load_valid, in, 1, load word present.
- load_data, in, DATA_W, load word.
- load_ready, out, 1, block accepts a load word.
- mem_we, out, 1, memory write strobe.
- mem_sel, out, 1, 0 = IMEM, 1 = DMEM.
- mem_addr, out, ADDR_W, word address.
- mem_wdata, out, DATA_W, write data.
- cpu_rst, out, 1, reset to the CPU under test.
- cpu_instr, in, 32, current CPU instruction.
- cpu_pc, in, 32, current CPU PC.
- busy, out, 1, sequence in progress.
- done, out, 1, sequence finished.
- status, out, 2, 00 none, 01 halted, 10 timeout.
- cycle_count, out, CNT_W, RUN cycles elapsed.
- halt_pc, out, 32, PC at trap.

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, LOAD_I, LOAD_D, CPU_RST, RUN and DONE.
REQ-004 In IDLE or DONE, start=1 SHALL enter CLEAR next cycle, zero cycle_count, set status=00 and drop done; start SHALL be ignored in every other state.
REQ-005 CLEAR SHALL write 0 to DMEM addresses 0..DMEM_WORDS-1, one per cycle (mem_we=1, mem_sel=1), then enter LOAD_I; duration is exactly DMEM_WORDS cycles.
REQ-006 In LOAD_I/LOAD_D, load_ready SHALL be 1; a word transfers only when load_valid && load_ready; each transfer writes the same cycle to IMEM/DMEM at an address counter starting at 0.
REQ-007 After IMEM_WORDS transfers the FSM SHALL enter LOAD_D; after DMEM_WORDS transfers it SHALL enter CPU_RST; no-transfer cycles SHALL stall without a write.
REQ-008 CPU_RST SHALL hold cpu_rst=1 for exactly RST_CYCLES cycles, then enter RUN; cpu_rst SHALL be 1 in IDLE, CLEAR, LOAD_I, LOAD_D, CPU_RST and DONE, and 0 only in RUN.
REQ-009 In RUN, cycle_count SHALL increment each cycle, saturating at 2^CNT_W-1.
REQ-010 In RUN, cpu_instr==TRAP_WORD SHALL latch halt_pc=cpu_pc, set status=01 and enter DONE next cycle.
REQ-011 In RUN, when cycle_count reaches MAX_CYCLES-1 without a trap, the block SHALL set status=10 and enter DONE; if a trap and the timeout occur in the same cycle, halted (01) SHALL win.
REQ-012 TRAP_WORD seen on cpu_instr outside RUN SHALL be ignored.
REQ-013 busy SHALL be 1 in CLEAR through RUN; done SHALL be 1 only in DONE; mem_we SHALL be 0 outside CLEAR, LOAD_I and LOAD_D.
REQ-014 status, halt_pc and cycle_count SHALL hold in DONE until the next accepted start.

Reset
REQ-015 reset SHALL, at the next edge and from any state, force IDLE.
REQ-016 reset SHALL set load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_sel=0, cpu_rst=1, busy=0, done=0, status=00, cycle_count=0 and halt_pc=0.
REQ-017 reset mid-load SHALL discard progress; no memory write SHALL occur in the reset cycle.

Configuration
REQ-018 With macro SIM_RUN_CTRL_TRACE_EN defined, the block SHALL add outputs retired_count (CNT_W) and last_pc (32), updated in RUN whenever cpu_pc changes, both cleared by reset and start; without the macro these ports and their logic SHALL be absent and all other behaviour identical.

Verification
REQ-019 IMEM_WORDS=4, DMEM_WORDS=4, RST_CYCLES=2: start pulse -> 4 DMEM zero writes to addresses 0..3, then load_ready=1.
REQ-020 Stream 8 words with load_valid toggling every other cycle -> 4 IMEM and 4 DMEM writes at addresses 0..3 each, with no writes on idle cycles.
REQ-021 After load -> cpu_rst high exactly 2 cycles, then RUN; cpu_instr=32'h44000300 with cpu_pc=32'h10 on RUN cycle 5 -> done=1, status=01, halt_pc=32'h10, cycle_count=5.
REQ-022 MAX_CYCLES=20 with no trap -> status=10 after 20 RUN cycles; a trap on the final cycle -> status=01.
REQ-023 reset asserted during LOAD_D -> IDLE, outputs at reset values; start in LOAD_I -> ignored; start in DONE -> a new sequence starts.
REQ-024 With SIM_RUN_CTRL_TRACE_EN defined: PC sequence 0,4,8,8,C in RUN -> retired_count=4, last_pc=32'hC.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run sequencer for a CPU under test.
// Sequence: clear DMEM, stream-load IMEM then DMEM, pulse CPU reset, then run
// until the trap instruction is seen or the cycle budget expires.
// Optional trace outputs (retired_count, last_pc) are built only when the
// macro SIM_RUN_CTRL_TRACE_EN is defined.
// Handshake: a load word transfers on a rising edge where load_valid and
// load_ready are both 1; load_ready does not depend on load_valid.
module sim_run_ctrl #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 10,
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter int          RST_CYCLES = 2,
  parameter int          MAX_CYCLES = 2500,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] TRAP_WORD  = 32'h44000300
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic [31:0]       cpu_instr,
  input  logic [31:0]       cpu_pc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [31:0]       halt_pc
`ifdef SIM_RUN_CTRL_TRACE_EN
  ,
  output logic [CNT_W-1:0]  retired_count,
  output logic [31:0]       last_pc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD_I  = 3'd2,
    S_LOAD_D  = 3'd3,
    S_CPU_RST = 3'd4,
    S_RUN     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DMEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] IMEM_LAST = ADDR_W'(IMEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] DMEM_LAST = ADDR_W'(DMEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] RST_LAST = ADDR_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;     // word address / reset-cycle index
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          status_q, status_d;
  logic [31:0]         halt_pc_q, halt_pc_d;
  logic                loading;

  assign loading = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);

  // Next-state and result-register logic for the run sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    halt_pc_d = halt_pc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_CLEAR;
          idx_d     = '0;
          cnt_d     = '0;
          status_d  = 2'b00;
          halt_pc_d = '0;
        end
      end
      S_CLEAR: begin
        if (idx_q == CLR_LAST) begin
          state_d = S_LOAD_I;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LOAD_I: begin
        if (load_valid) begin
          if (idx_q == IMEM_LAST) begin
            state_d = S_LOAD_D;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LOAD_D: begin
        if (load_valid) begin
          if (idx_q == DMEM_LAST) begin
            state_d = S_CPU_RST;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_CPU_RST: begin
        if (idx_q == RST_LAST) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A trap in the timeout cycle takes priority over the timeout.
        if (cpu_instr == TRAP_WORD) begin
          halt_pc_d = cpu_pc;
          status_d  = 2'b01;
          state_d   = S_DONE;
        end else if (cnt_q == TIMEOUT_AT) begin
          status_d = 2'b10;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      status_q  <= 2'b00;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  // Memory strobes are blocked while reset is high so an aborted load never writes.
  assign load_ready  = !reset && loading;
  assign mem_we      = !reset && ((state_q == S_CLEAR) || (loading && load_valid));
  assign mem_sel     = (state_q == S_CLEAR) || (state_q == S_LOAD_D);
  assign mem_addr    = ((state_q == S_CLEAR) || loading) ? idx_q : '0;
  assign mem_wdata   = loading ? load_data : '0;
  assign cpu_rst     = (state_q != S_RUN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign status      = status_q;
  assign cycle_count = cnt_q;
  assign halt_pc     = halt_pc_q;

`ifdef SIM_RUN_CTRL_TRACE_EN
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic             pc_seen_q, pc_seen_d;

  // The first RUN cycle always records a PC; afterwards only PC changes count.
  always_comb begin
    ret_d     = ret_q;
    last_pc_d = last_pc_q;
    pc_seen_d = pc_seen_q;
    if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
      ret_d     = '0;
      last_pc_d = '0;
      pc_seen_d = 1'b0;
    end else if ((state_q == S_RUN) && (!pc_seen_q || (cpu_pc != last_pc_q))) begin
      pc_seen_d = 1'b1;
      last_pc_d = cpu_pc;
      if (ret_q != CNT_MAX) ret_d = ret_q + 1'b1;
    end
  end

  // Trace registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ret_q     <= '0;
      last_pc_q <= '0;
      pc_seen_q <= 1'b0;
    end else begin
      ret_q     <= ret_d;
      last_pc_q <= last_pc_d;
      pc_seen_q <= pc_seen_d;
    end
  end

  assign retired_count = ret_q;
  assign last_pc       = last_pc_q;
`endif

endmodule
